ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
PS/2 keyboard receiver for the board top level. It sits between the PS2_CLK/PS2_DATA pins and the CPU's memory-mapped keyboard port (kbd_data, kbd_ready, kbd_overflow, kbd_read_enable).
- Oversamples the PS/2 lines on the CPU clock (1 MHz) and deserialises 11-bit frames.
- Checks parity and framing, then buffers good scancodes in a FIFO that the CPU drains with a read pulse.
- ready and overflow are also driven to board LEDs.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
TIMEOUT, 2000, clk cycles with no PS/2 falling edge mid-frame before the frame is aborted (2 ms at 1 MHz).

Ports:
clk  in  1  system clock (CPU clock, 1 MHz); all logic is on its rising edge
rst  in  1  asynchronous, active-low reset; low clears all state
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
read_enable  in  1  pop request; one-cycle pulse from the CPU
data  out  8  scancode at the FIFO head; 8'h00 when empty
ready  out  1  FIFO not empty
overflow  out  1  sticky flag: a good frame was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse on a parity or stop-bit error

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; FIFO pointers and count go to 0.
  - data=0, ready=0, overflow=0, frame_err=0; synchroniser and filter registers go to 1.
  - Reset mid-frame discards the partial frame. After release, reception restarts at the next start bit.
- Input conditioning:
  - Each pin passes through a 2-FF synchroniser.
  - ps2_clk then feeds a 3-bit shift history h.
  - A falling edge ("fe") is a single-cycle strobe when h==3'b100 (high, then two consecutive low samples); this rejects 1-cycle glitches.
  - Data is sampled from the synchronised ps2_data in the fe cycle.
- Frame: start(0), D0..D7 (LSB first), parity (odd over D0..D7 plus parity), stop(1).
- FSM states and transitions:
  - IDLE: on fe with data 0, go to DATA and clear bit_cnt. On fe with data 1, stay in IDLE (spurious edge).
  - DATA: on each fe, shift the bit into sr[7] (right shift) and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: on fe, latch the parity bit and go to STOP.
  - STOP: on fe, go to IDLE.
    - Frame good (stop==1 and ^{sr,parity}==1): push sr.
    - Frame bad: no push; assert frame_err for that cycle.
- Timeout:
  - A timer clears on every fe and counts in DATA/PARITY/STOP.
  - When it reaches TIMEOUT-1, the FSM returns to IDLE and the partial byte is discarded.
  - A timeout does not pulse frame_err.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap, plus a count of width log2(DEPTH)+1.
  - data = mem[rd_ptr] when count!=0, else 0 (combinational from registers).
  - ready = (count!=0).
  - Push latency: the byte is on data and ready is 1 in the cycle after the stop-bit fe cycle.
- Read rules:
  - read_enable with ready pops on that clk edge; the next entry appears the following cycle.
  - read_enable when empty is ignored.
  - read_enable held high pops one entry per cycle.
- Simultaneous push and pop:
  - Both happen and count is unchanged.
  - This applies when full too: the pop frees a slot, the push is accepted, and overflow is not set.
- Overflow:
  - Push while full without a pop: the byte is dropped, FIFO contents are unchanged, overflow is set.
  - overflow clears on the first accepted pop.
  - Set and clear in the same cycle cannot occur (the simultaneous case is accepted instead).

Decomposition:
- Shared package holds:
  - state enum IDLE/DATA/PARITY/STOP (2 bits);
  - PS2_DATA_BITS=8;
  - localparam for the glitch-filter pattern 3'b100.
- Sub-module ps2_byte_fifo (DEPTH; push, pop, din, dout, count, full, empty) holds the buffer and pointers.
- Top level holds the synchronisers, filter, FSM, timer, and overflow/frame_err logic.

Test Plan:
1. Send frame 0x1C (parity 0, stop 1) at a 12.5 kHz PS/2 clock -> ready=1, data=8'h1C one cycle after the stop edge; a read_enable pulse -> ready=0, data=0 next cycle.
2. Send 0xF0, 0x1C back-to-back, then read twice -> data 8'hF0 then 8'h1C in order; overflow=0 and frame_err never asserted.
3. Send 0x1C with parity=1, then 0x1C with stop=0 -> two single-cycle frame_err pulses; ready stays 0.
4. Send 9 frames 0x01..0x09 without reading -> overflow=1 after the 9th; 8 reads return 0x01..0x08. overflow clears on the first read; ready=0 after the 8th.
5. Send a start bit plus 4 data bits, idle for 2500 clk cycles, then send 0x5A -> no frame_err; data=8'h5A with ready=1.
6. Fill the FIFO with 8 bytes and assert read_enable in the exact stop-edge cycle of a 9th frame 0x33 -> count stays 8 and overflow=0; 0x33 is returned 8th. Also: a 1-cycle low glitch on ps2_clk in IDLE is ignored, and rst low mid-frame gives all outputs 0 with the next frame received cleanly.

Source files
------------

// File: rtl/ps2_rx_fifo_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the PS/2 receive path.
package ps2_rx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_DATA_BITS = 8;

  // High followed by two low samples: a real falling edge, not a 1-cycle glitch.
  localparam logic [2:0] FE_PATTERN = 3'b100;

endpackage

// File: rtl/ps2_byte_fifo.sv
`timescale 1ns/1ps
// Circular scancode buffer. The caller only pushes when not full (or when
// popping in the same cycle) and only pops when not empty.
module ps2_byte_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PS2_DATA_BITS-1:0]   din,
  output logic [PS2_DATA_BITS-1:0]   dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PS2_DATA_BITS-1:0] mem_q [DEPTH];
  logic [PS2_DATA_BITS-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver: pin conditioning, frame FSM with timeout, and a
// scancode FIFO drained by the CPU keyboard port.
//
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (fe with data 0)
//   ST_DATA   | shifting in D0..D7, LSB first
//   ST_PARITY | waiting for the odd-parity bit
//   ST_STOP   | waiting for the stop bit; push or flag error on its edge
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 2000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     read_enable,
  output logic [PS2_DATA_BITS-1:0] data,
  output logic                     ready,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int TMR_W  = $clog2(TIMEOUT);
  localparam int BCNT_W = $clog2(PS2_DATA_BITS);

  logic                     clk_meta_q, clk_sync_q;
  logic                     dat_meta_q, dat_sync_q;
  logic [2:0]               hist_q, hist_d;
  ps2_state_e               state_q, state_d;
  logic [BCNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] sr_q, sr_d;
  logic                     par_q, par_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic                     overflow_q, overflow_d;

  logic                     fe, timeout;
  logic                     frame_good, stop_fe, push_req;
  logic                     push_acc, pop;
  logic                     fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      hist_q     <= 3'b111;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      par_q      <= 1'b0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      hist_q     <= hist_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      par_q      <= par_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
    end
  end

  assign hist_d  = {hist_q[1:0], clk_sync_q};
  assign fe      = (hist_q == FE_PATTERN);
  assign timeout = (timer_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    par_d     = par_q;
    timer_d   = timer_q + TMR_W'(1);
    if (state_q == ST_IDLE || fe || timeout) timer_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (fe && !dat_sync_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fe) begin
          sr_d      = {dat_sync_q, sr_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (bit_cnt_q == BCNT_W'(PS2_DATA_BITS - 1)) state_d = ST_PARITY;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_PARITY: begin
        if (fe) begin
          par_d   = dat_sync_q;
          state_d = ST_STOP;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_STOP: begin
        if (fe || timeout) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  always_comb begin
    frame_good = dat_sync_q && (^{sr_q, par_q});
    stop_fe    = (state_q == ST_STOP) && fe;
    push_req   = stop_fe && frame_good;
    frame_err  = stop_fe && !frame_good;
    pop        = read_enable && (fifo_count != '0);
    push_acc   = push_req && (!fifo_full || pop);
    overflow_d = overflow_q;
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;
    else if (pop)                      overflow_d = 1'b0;
  end

  ps2_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_acc),
    .pop   (pop),
    .din   (sr_q),
    .dout  (data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready    = !fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
// Directed bench for ps2_rx_fifo: 1 MHz system clock, 12.5 kHz PS/2 clock.
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       read_enable = 1'b0;
  logic [7:0] data;
  logic       ready, overflow, frame_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  always #500 clk = ~clk;

  ps2_rx_fifo #(.DEPTH(8), .TIMEOUT(2000)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .read_enable (read_enable),
    .data        (data),
    .ready       (ready),
    .overflow    (overflow),
    .frame_err   (frame_err)
  );

  always @(negedge clk) if (frame_err) err_pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(40);
    ps2_clk = 1'b1;
    wait_cyc(20);
  endtask

  // mode 0: plain; 1: check push latency around the stop edge; 2: pulse read in the stop-edge cycle
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int mode);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_data = stp;
    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(4);
    if (mode == 1) begin
      chk("lat_ready_in_fe_cycle", ready, 0);
      wait_cyc(1);
      chk("lat_ready_next_cycle", ready, 1);
      chk("lat_data_next_cycle", data, b);
      wait_cyc(35);
    end else if (mode == 2) begin
      read_enable = 1'b1;
      wait_cyc(1);
      read_enable = 1'b0;
      wait_cyc(35);
    end else begin
      wait_cyc(36);
    end
    ps2_clk = 1'b1;
    wait_cyc(20);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1, 0);
  endtask

  task automatic read_chk(input string tag, input logic [7:0] exp);
    chk(tag, data, exp);
    read_enable = 1'b1;
    wait_cyc(1);
    read_enable = 1'b0;
  endtask

  initial begin
    logic [7:0] b33;
    rst = 1'b0;
    wait_cyc(3);
    chk("rst_data", data, 0);
    chk("rst_ready", ready, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b1;
    wait_cyc(5);

    // single frame, exact latency, then pop
    send_frame(8'h1C, 1'b0, 1'b1, 1);
    read_chk("t1_data", 8'h1C);
    chk("t1_ready_after_pop", ready, 0);
    chk("t1_data_after_pop", data, 0);

    // back-to-back frames, FIFO order
    good(8'hF0);
    good(8'h1C);
    chk("t2_overflow", overflow, 0);
    read_chk("t2_first", 8'hF0);
    read_chk("t2_second", 8'h1C);
    chk("t2_ready_empty", ready, 0);
    chk("t2_no_frame_err", err_pulses, 0);

    // bad parity, then bad stop
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    chk("t3_err_pulses", err_pulses, 2);
    chk("t3_ready", ready, 0);

    // fill, overflow, drain
    for (int i = 1; i <= 8; i++) good(8'(i));
    chk("t4_no_overflow_at_full", overflow, 0);
    chk("t4_ready_full", ready, 1);
    good(8'h09);
    chk("t4_overflow_set", overflow, 1);
    read_chk("t4_rd1", 8'h01);
    chk("t4_overflow_cleared", overflow, 0);
    for (int i = 2; i <= 8; i++) read_chk("t4_rd", 8'(i));
    chk("t4_ready_drained", ready, 0);
    chk("t4_data_drained", data, 0);

    // partial frame aborted by timeout
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    wait_cyc(2500);
    good(8'h5A);
    chk("t5_no_frame_err", err_pulses, 2);
    chk("t5_ready", ready, 1);
    read_chk("t5_data", 8'h5A);
    chk("t5_ready_empty", ready, 0);

    // push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) good(8'h11 + 8'(i));
    b33 = 8'h33;
    send_frame(b33, ~^b33, 1'b1, 2);
    chk("t6_overflow", overflow, 0);
    chk("t6_ready", ready, 1);
    for (int i = 1; i < 8; i++) read_chk("t6_rd", 8'h11 + 8'(i));
    read_chk("t6_rd_last", 8'h33);
    chk("t6_ready_empty", ready, 0);
    chk("t6_overflow_end", overflow, 0);

    // one-cycle glitch on ps2_clk with data low must not start a frame
    ps2_data = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(1);
    ps2_clk = 1'b1;
    wait_cyc(10);
    ps2_data = 1'b1;
    wait_cyc(10);
    good(8'h22);
    read_chk("glitch_data", 8'h22);
    chk("glitch_no_err", err_pulses, 2);

    // asynchronous reset mid-frame
    good(8'h44);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    rst = 1'b0;
    #100;
    chk("rstmid_data", data, 0);
    chk("rstmid_ready", ready, 0);
    chk("rstmid_overflow", overflow, 0);
    chk("rstmid_frame_err", frame_err, 0);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(5);
    good(8'h66);
    chk("rstmid_next_ready", ready, 1);
    read_chk("rstmid_next_data", 8'h66);
    chk("rstmid_no_err", err_pulses, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
